// File: rtl/cpu_program_loader_if.sv
// Byte-stream link into the program loader: valid/ready transfer of one byte.
// A byte moves when rx_valid and rx_ready are both high at a rising clk edge.
interface cpu_program_loader_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    // Byte source (UART receiver or test host)
    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    // Byte sink (the loader)
    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/cpu_program_loader.sv
// Boot controller: frames MAGIC, count, then {hi,lo} byte pairs into 16-bit
// words on the CPU icache write port. write doubles as the CPU hold.
// Optional trailer checksum byte: define LOADER_CHECKSUM_EN.
module cpu_program_loader #(
    parameter logic [7:0]  MAGIC = 8'hA5,
    parameter int unsigned IDX_W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    cpu_program_loader_if.slave       rx,
    output logic                      write,
    output logic [IDX_W-1:0]          write_instruction_index,
    output logic [15:0]               write_instruction,
    output logic                      loading,
    output logic                      done,
    output logic                      error
);

    localparam int unsigned CNT_W = IDX_W + 1;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COUNT  = 3'd1,
        HI     = 3'd2,
        LO     = 3'd3,
        COMMIT = 3'd4,
        CSUM   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        COUNT  = 3'd1,
        HI     = 3'd2,
        LO     = 3'd3,
        COMMIT = 3'd4
    } state_t;
`endif

    state_t             state, state_n;
    logic [CNT_W-1:0]   word_count, word_count_n;
    logic [CNT_W-1:0]   words_written, words_written_n;
    logic [IDX_W-1:0]   index_n;
    logic [15:0]        instr_n;
    logic               write_n;
    logic               loading_n;
    logic               done_n;
    logic               ready_q, ready_n;
    logic               accept;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]         csum, csum_n;
    logic               error_q, error_n;
`endif

    assign accept      = rx.rx_valid && ready_q;
    assign rx.rx_ready = ready_q;

`ifdef LOADER_CHECKSUM_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        state_n         = state;
        word_count_n    = word_count;
        words_written_n = words_written;
        index_n         = write_instruction_index;
        instr_n         = write_instruction;
        loading_n       = loading;
        done_n          = done;
`ifdef LOADER_CHECKSUM_EN
        csum_n          = csum;
        error_n         = error_q;
`endif

        case (state)
            IDLE: begin
                if (accept && rx.rx_data == MAGIC) begin
                    state_n   = COUNT;
                    loading_n = 1'b1;
                    done_n    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    error_n   = 1'b0;
`endif
                end
            end
            COUNT: begin
                if (accept) begin
                    // A zero count byte stands for a full 2^IDX_W image
                    if (rx.rx_data == 8'h00) begin
                        word_count_n = CNT_W'(1) << IDX_W;
                    end else begin
                        word_count_n = CNT_W'(rx.rx_data);
                    end
                    words_written_n = '0;
                    index_n         = '0;
                    state_n         = HI;
`ifdef LOADER_CHECKSUM_EN
                    csum_n          = rx.rx_data;
`endif
                end
            end
            HI: begin
                if (accept) begin
                    instr_n[15:8] = rx.rx_data;
                    state_n       = LO;
`ifdef LOADER_CHECKSUM_EN
                    csum_n        = csum ^ rx.rx_data;
`endif
                end
            end
            LO: begin
                if (accept) begin
                    instr_n[7:0] = rx.rx_data;
                    state_n      = COMMIT;
`ifdef LOADER_CHECKSUM_EN
                    csum_n       = csum ^ rx.rx_data;
`endif
                end
            end
            COMMIT: begin
                words_written_n = words_written + CNT_W'(1);
                if (words_written + CNT_W'(1) == word_count) begin
`ifdef LOADER_CHECKSUM_EN
                    state_n   = CSUM;
`else
                    state_n   = IDLE;
                    loading_n = 1'b0;
                    done_n    = 1'b1;
`endif
                end else begin
                    index_n = write_instruction_index + IDX_W'(1);
                    state_n = HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) begin
                    loading_n = 1'b0;
                    state_n   = IDLE;
                    if (rx.rx_data == csum) begin
                        done_n  = 1'b1;
                    end else begin
                        done_n  = 1'b0;
                        error_n = 1'b1;
                    end
                end
            end
`endif
            default: begin
                state_n = IDLE;
            end
        endcase

        // Hold the CPU and keep the icache port live while a word is in flight
        write_n = (state_n == HI) || (state_n == LO) || (state_n == COMMIT);
        ready_n = (state_n != COMMIT);
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_count              <= '0;
            words_written           <= '0;
            write_instruction_index <= '0;
            write_instruction       <= 16'h0000;
            write                   <= 1'b0;
            loading                 <= 1'b0;
            done                    <= 1'b0;
            ready_q                 <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum                    <= 8'h00;
            error_q                 <= 1'b0;
`endif
        end else begin
            word_count              <= word_count_n;
            words_written           <= words_written_n;
            write_instruction_index <= index_n;
            write_instruction       <= instr_n;
            write                   <= write_n;
            loading                 <= loading_n;
            done                    <= done_n;
            ready_q                 <= ready_n;
`ifdef LOADER_CHECKSUM_EN
            csum                    <= csum_n;
            error_q                 <= error_n;
`endif
        end
    end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Directed bench for cpu_program_loader with a behavioural icache model.
module tb_cpu_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        write;
    logic [7:0]  idx;
    logic [15:0] wi;
    logic        loading;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    cpu_program_loader_if bus();

    cpu_program_loader dut (
        .clk                     (clk),
        .reset                   (reset),
        .rx                      (bus),
        .write                   (write),
        .write_instruction_index (idx),
        .write_instruction       (wi),
        .loading                 (loading),
        .done                    (done),
        .error                   (error)
    );

    always #5 clk = ~clk;

    // Icache model: stores the presented word on every clock while write is high
    logic [15:0] icache [256];
    always @(posedge clk) begin
        if (write) icache[idx] <= wi;
    end

    // Free-running observation counters, sampled mid-cycle
    int cycles_wr   = 0;
    int cycles_nrdy = 0;
    int last_idx    = -1;
    always @(negedge clk) begin
        if (write) begin
            cycles_wr = cycles_wr + 1;
            last_idx  = int'(idx);
        end
        if (!bus.rx_ready) cycles_nrdy = cycles_nrdy + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Present one byte from a negedge; returns at the negedge after the transfer
    task automatic send(input logic [7:0] b);
        int n;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        n = 0;
        while (!bus.rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("send_timeout", 32'(bus.rx_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_gap(input logic [7:0] b);
        send(b);
        bus.rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_csum(input logic [7:0] c);
`ifdef LOADER_CHECKSUM_EN
        send(c);
`else
        bus.rx_data = c;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int w0, r0, bad;
        logic [7:0] cs;
        logic [7:0] k8;

        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        @(negedge clk);
        check("rst_write",   32'(write),        32'd0);
        check("rst_index",   32'(idx),          32'd0);
        check("rst_instr",   32'(wi),           32'h0000);
        check("rst_loading", 32'(loading),      32'd0);
        check("rst_done",    32'(done),         32'd0);
        check("rst_error",   32'(error),        32'd0);
        check("rst_ready",   32'(bus.rx_ready), 32'd1);
        reset = 1'b0;
        @(negedge clk);

        // Two-word frame, continuous valid
        w0 = cycles_wr;
        r0 = cycles_nrdy;
        send(8'hA5);
        check("a_loading", 32'(loading), 32'd1);
        send(8'h02);
        check("a_write_on", 32'(write), 32'd1);
        send(8'h12);
        send(8'h34);
        send(8'h56);
        send(8'h78);
        send_csum(8'h0A);
        idle(4);
        check("a_word0",   32'(icache[0]), 32'h1234);
        check("a_word1",   32'(icache[1]), 32'h5678);
        check("a_write",   32'(write),     32'd0);
        check("a_loading_end", 32'(loading), 32'd0);
        check("a_done",    32'(done),      32'd1);
        check("a_error",   32'(error),     32'd0);
        check("a_index",   32'(idx),       32'd1);
        check("a_wr_cyc",  32'(cycles_wr - w0),   32'd6);
        check("a_nrdy",    32'(cycles_nrdy - r0), 32'd2);

        // Junk before sync is dropped
        send(8'h00);
        send(8'hFF);
        check("b_idle_loading", 32'(loading), 32'd0);
        send(8'hA5);
        check("b_done_clr", 32'(done), 32'd0);
        send(8'h01);
        send(8'hAB);
        send(8'hCD);
        send_csum(8'h67);
        idle(4);
        check("b_word0", 32'(icache[0]), 32'hABCD);
        check("b_word1", 32'(icache[1]), 32'h5678);
        check("b_done",  32'(done),      32'd1);
        check("b_index", 32'(idx),       32'd0);

        // Count 0 means a full 256-word image
        w0 = cycles_wr;
        send(8'hA5);
        send(8'h00);
        cs = 8'h00;
        for (int k = 0; k < 256; k++) begin
            k8 = 8'(k);
            send(k8);
            send(k8 ^ 8'h5A);
            cs = cs ^ k8 ^ (k8 ^ 8'h5A);
        end
        send_csum(cs);
        idle(4);
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            k8 = 8'(k);
            if (icache[k] !== {k8, k8 ^ 8'h5A}) bad++;
        end
        check("c_bad_words", 32'(bad),             32'd0);
        check("c_word0",     32'(icache[0]),       32'h005A);
        check("c_word255",   32'(icache[255]),     32'hFFA5);
        check("c_last_idx",  32'(last_idx),        32'd255);
        check("c_index",     32'(idx),             32'd255);
        check("c_wr_cyc",    32'(cycles_wr - w0),  32'd768);
        check("c_write",     32'(write),           32'd0);
        check("c_done",      32'(done),            32'd1);

        // Asynchronous reset in the middle of a frame
        send(8'hA5);
        send(8'h03);
        send(8'h11);
        check("d_write_pre", 32'(write), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("d_write",   32'(write),   32'd0);
        check("d_loading", 32'(loading), 32'd0);
        check("d_done",    32'(done),    32'd0);
        check("d_index",   32'(idx),     32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(8'hA5);
        send(8'h01);
        send(8'h22);
        send(8'h33);
        send_csum(8'h10);
        idle(4);
        check("d_word0", 32'(icache[0]), 32'h2233);
        check("d_done2", 32'(done),      32'd1);

        // Valid toggling every cycle
        send_gap(8'hA5);
        send_gap(8'h01);
        send(8'h9A);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("e_hold_hi",  32'(wi[15:8]), 32'h9A);
        check("e_hold_wr",  32'(write),    32'd1);
        check("e_hold_rdy", 32'(bus.rx_ready), 32'd1);
        send_gap(8'hBC);
`ifdef LOADER_CHECKSUM_EN
        send_gap(8'h27);
`endif
        idle(4);
        check("e_word0", 32'(icache[0]), 32'h9ABC);
        check("e_done",  32'(done),      32'd1);
        check("e_write", 32'(write),     32'd0);

`ifdef LOADER_CHECKSUM_EN
        // Trailer checksum: match, then mismatch
        send(8'hA5);
        send(8'h01);
        send(8'h12);
        send(8'h34);
        @(negedge clk);
        check("f_csum_write",   32'(write),   32'd0);
        check("f_csum_loading", 32'(loading), 32'd1);
        send(8'h27);
        idle(2);
        check("f_ok_done",    32'(done),    32'd1);
        check("f_ok_error",   32'(error),   32'd0);
        check("f_ok_loading", 32'(loading), 32'd0);
        send(8'hA5);
        send(8'h01);
        send(8'h12);
        send(8'h34);
        send(8'h00);
        idle(2);
        check("f_bad_done",    32'(done),    32'd0);
        check("f_bad_error",   32'(error),   32'd1);
        check("f_bad_loading", 32'(loading), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
